// File: rtl/uart_parity_engine_if.sv
// -----------------------------------------------------------------------------
// uart_parity_engine_if
//
// Bundles the control, strobe and result signals of uart_parity_engine.
// clk and reset are plain ports on the engine and are not part of this bundle.
//
// Handshake semantics (the one place they are written down):
//   start      : one-cycle request. It begins a new frame from any state and
//                latches parity_type/check_en. Any frame in flight is dropped.
//   bit_valid  : qualifies bit_in. It is only consumed while busy is high and
//                dbg_state is ACCUM. There is no back-pressure, so every strobe
//                in that state is taken.
//   chk_valid  : qualifies chk_bit. It is only consumed in WAIT_CHK. There is
//                no back-pressure.
//   parity_valid / parity_err : one-cycle result pulses. The consumer must
//                sample them in that cycle; they are not held.
//
// Modports:
//   master : drives the requests and observes the results (the shifter side).
//   slave  : the parity engine itself.
// -----------------------------------------------------------------------------
interface uart_parity_engine_if #(
  parameter int ERR_CNT_W = 8
);
  // requests
  logic [2:0]           parity_type;
  logic                 check_en;
  logic                 start;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 chk_valid;
  logic                 chk_bit;
  logic                 clr_err;
  // results
  logic                 busy;
  logic                 parity_valid;
  logic                 parity_bit;
  logic                 parity_err;
  logic [ERR_CNT_W-1:0] err_count;
  // FSM state: 0 IDLE, 1 ACCUM, 2 DONE, 3 WAIT_CHK
  logic [1:0]           dbg_state;

  modport master (
    output parity_type, check_en, start, bit_valid, bit_in,
           chk_valid, chk_bit, clr_err,
    input  busy, parity_valid, parity_bit, parity_err, err_count, dbg_state
  );

  modport slave (
    input  parity_type, check_en, start, bit_valid, bit_in,
           chk_valid, chk_bit, clr_err,
    output busy, parity_valid, parity_bit, parity_err, err_count, dbg_state
  );
endinterface

// File: rtl/uart_parity_engine.sv
// -----------------------------------------------------------------------------
// uart_parity_engine
//
// Serial parity generator/checker for the UART Tx and Rx datapaths. Parity is
// accumulated one bit at a time as the shifter moves bits, so no parallel data
// bus is needed. Modes: none, odd, even, mark (always 1), space (always 0).
// On the Rx side the received parity bit is compared against the computed one.
// A mismatch pulses parity_err and, optionally, bumps a saturating counter.
//
// Parameters:
//   DATA_WIDTH : character bits per frame. The legal range is 5..9.
//   ERR_CNT_W  : width of the saturating parity-error counter.
//
// Ports:
//   clk    : system clock, rising edge.
//   reset  : asynchronous, active-high reset.
//   pif    : uart_parity_engine_if.slave (requests, strobes and results).
//
// Build option:
//   UART_PARITY_ERRCNT_EN : when defined, err_count is a saturating count of
//                           parity errors that clr_err clears. When undefined,
//                           err_count is tied to 0 and clr_err is ignored.
// -----------------------------------------------------------------------------
module uart_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_parity_engine_if.slave   pif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_DONE     = 2'd2,
    S_WAIT_CHK = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    M_NONE  = 3'd0,
    M_ODD   = 3'd1,
    M_EVEN  = 3'd2,
    M_MARK  = 3'd3,
    M_SPACE = 3'd4
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in;
  logic             check_q, check_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d;
  logic             acc_next;

  // Codes 101..111 fall back to none.
  always_comb begin
    mode_in = M_NONE;
    case (pif.parity_type)
      3'b001:  mode_in = M_ODD;
      3'b010:  mode_in = M_EVEN;
      3'b011:  mode_in = M_MARK;
      3'b100:  mode_in = M_SPACE;
      default: mode_in = M_NONE;
    endcase
  end

  // Map the XOR of the data bits to the parity bit for the latched mode.
  function automatic logic final_parity(input mode_e mode, input logic acc);
    logic p;
    case (mode)
      M_ODD:   p = ~acc;
      M_EVEN:  p = acc;
      M_MARK:  p = 1'b1;
      M_SPACE: p = 1'b0;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  assign acc_next = acc_q ^ pif.bit_in;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    check_d   = check_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start is handled below, uniformly for all states
      end

      S_ACCUM: begin
        if (pif.bit_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d   = S_DONE;
            // Register the frame's parity on entry to DONE, so parity_bit is
            // already final during the parity_valid cycle.
            par_bit_d = final_parity(mode_q, acc_next);
          end
        end
      end

      S_DONE: begin
        if (check_q && (mode_q != M_NONE)) state_d = S_WAIT_CHK;
        else                               state_d = S_IDLE;
      end

      S_WAIT_CHK: begin
        if (pif.chk_valid) begin
          par_err_d = pif.chk_bit ^ par_bit_q;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // start wins over everything else. It drops any frame in flight and
    // discards same-cycle strobes. It suppresses a pending check, but a
    // parity_valid already in progress in DONE still shows, because that is
    // decoded from the current state.
    if (pif.start) begin
      state_d   = S_ACCUM;
      mode_d    = mode_in;
      check_d   = pif.check_en;
      acc_d     = 1'b0;
      cnt_d     = '0;
      par_bit_d = par_bit_q;
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_NONE;
      check_q   <= 1'b0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      par_bit_q <= 1'b1;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      check_q   <= check_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
    end
  end

  assign pif.busy         = (state_q == S_ACCUM) || (state_q == S_WAIT_CHK);
  assign pif.parity_valid = (state_q == S_DONE);
  assign pif.parity_bit   = par_bit_q;
  assign pif.parity_err   = par_err_q;
  assign pif.dbg_state    = state_q;

`ifdef UART_PARITY_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // The counter moves on the same edge that raises parity_err, so the new
  // count is visible together with the pulse. A clear in that cycle wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pif.clr_err)
      err_cnt_d = '0;
    else if (par_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign pif.err_count = err_cnt_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = pif.clr_err;
  assign pif.err_count  = '0;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
module tb_uart_parity_engine;

  localparam int DW        = 8;
  localparam int ERR_CNT_W = 2;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef UART_PARITY_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_parity_engine_if #(.ERR_CNT_W(ERR_CNT_W)) pif ();

  uart_parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every parity_valid pulse consumes one expected parity bit.
  always @(negedge clk) begin
    if (!reset && pif.parity_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_parity_valid: got 1 expected 0 at %0t", $time);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("parity_bit", {31'd0, pif.parity_bit}, {31'd0, e});
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [2:0] ptype;
    logic       ce;
    logic [7:0] data;
    logic       do_chk;
    logic       chk_bit;
    logic       clr;
    logic       exp_par;
    logic       exp_wait;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] data);
    for (int i = 0; i < DW; i++) begin
      pif.bit_valid = 1'b1;
      pif.bit_in    = data[i];
      tick();
    end
    pif.bit_valid = 1'b0;
    pif.bit_in    = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    pif.start       = 1'b1;
    pif.parity_type = v.ptype;
    pif.check_en    = v.ce;
    tick();
    pif.start = 1'b0;
    exp_q.push_back(v.exp_par);
    check("busy_accum", {31'd0, pif.busy}, 32'd1);
    send_bits(v.data);
    check("parity_valid_latency", {31'd0, pif.parity_valid}, 32'd1);
    tick();
    check("busy_after_done", {31'd0, pif.busy}, {31'd0, v.exp_wait});
    check("parity_valid_one_cycle", {31'd0, pif.parity_valid}, 32'd0);
    if (v.do_chk) begin
      pif.chk_valid = 1'b1;
      pif.chk_bit   = v.chk_bit;
      pif.clr_err   = v.clr;
      tick();
      pif.chk_valid = 1'b0;
      pif.clr_err   = 1'b0;
      if (v.clr) exp_cnt = 0;
      else if (v.exp_err && exp_cnt < CNT_MAX) exp_cnt++;
      if (!CNT_EN) exp_cnt = 0;
      check("parity_err", {31'd0, pif.parity_err}, {31'd0, v.exp_err});
      check("err_count", {30'd0, pif.err_count}, exp_cnt);
      tick();
      check("parity_err_pulse_end", {31'd0, pif.parity_err}, 32'd0);
      check("busy_idle", {31'd0, pif.busy}, 32'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    // ptype ce data do_chk chk_bit clr exp_par exp_wait exp_err
    vecs[0]  = '{3'd2, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{3'd3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'd4, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd7, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{3'd1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{3'd2, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'd4, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'd3, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{3'd1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{3'd2, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{3'd5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset           = 1'b1;
    pif.parity_type = 3'd0;
    pif.check_en    = 1'b0;
    pif.start       = 1'b0;
    pif.bit_valid   = 1'b0;
    pif.bit_in      = 1'b0;
    pif.chk_valid   = 1'b0;
    pif.chk_bit     = 1'b0;
    pif.clr_err     = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, pif.busy}, 32'd0);
    check("rst_parity_valid", {31'd0, pif.parity_valid}, 32'd0);
    check("rst_parity_bit", {31'd0, pif.parity_bit}, 32'd1);
    check("rst_parity_err", {31'd0, pif.parity_err}, 32'd0);
    check("rst_err_count", {30'd0, pif.err_count}, 32'd0);
    check("rst_state", {30'd0, pif.dbg_state}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run_frame(vecs[i]);

    // Abort in ACCUM: start coincides with a bit_valid of 1 that must be dropped.
    pif.start = 1'b1; pif.parity_type = 3'd2; pif.check_en = 1'b0;
    tick();
    pif.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pif.bit_valid = 1'b1; pif.bit_in = 1'b1;
      tick();
    end
    pif.start = 1'b1; pif.bit_valid = 1'b1; pif.bit_in = 1'b1;
    tick();
    pif.start = 1'b0;
    exp_q.push_back(1'b1);
    send_bits(8'h01);
    check("abort_parity_valid", {31'd0, pif.parity_valid}, 32'd1);
    tick();
    check("abort_busy", {31'd0, pif.busy}, 32'd0);

    // Abort in WAIT_CHK: a mismatching chk_valid in the start cycle is discarded.
    v = '{3'd1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame(v);
    pif.start = 1'b1; pif.parity_type = 3'd2; pif.check_en = 1'b0;
    pif.chk_valid = 1'b1; pif.chk_bit = 1'b1;
    tick();
    pif.start = 1'b0; pif.chk_valid = 1'b0;
    check("abort_wait_no_err", {31'd0, pif.parity_err}, 32'd0);
    check("abort_wait_state", {30'd0, pif.dbg_state}, 32'd1);
    exp_q.push_back(1'b0);
    send_bits(8'h00);
    // Start in DONE: this cycle's parity_valid still shows, and a new frame begins.
    check("done_parity_valid", {31'd0, pif.parity_valid}, 32'd1);
    pif.start = 1'b1; pif.parity_type = 3'd4; pif.check_en = 1'b0;
    tick();
    pif.start = 1'b0;
    check("restart_from_done", {30'd0, pif.dbg_state}, 32'd1);
    exp_q.push_back(1'b0);
    send_bits(8'hFF);
    tick();
    check("restart_idle", {31'd0, pif.busy}, 32'd0);

    // Reset while waiting for the check bit.
    v = '{3'd1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_frame(v);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, pif.busy}, 32'd0);
    check("mid_rst_parity_bit", {31'd0, pif.parity_bit}, 32'd1);
    check("mid_rst_err_count", {30'd0, pif.err_count}, 32'd0);
    check("mid_rst_parity_err", {31'd0, pif.parity_err}, 32'd0);
    check("mid_rst_state", {30'd0, pif.dbg_state}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_parity_err", {31'd0, pif.parity_err}, 32'd0);
    check("post_rst_busy", {31'd0, pif.busy}, 32'd0);

    tick();
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
- Serial parity generator/checker for the UART Tx and Rx datapaths, parametrised in character width.
- Adds mark and space modes to none/odd/even.
- Accumulates parity one bit at a time as the shifter moves bits, so no parallel data bus is needed.
- On the Rx side it compares the received parity bit, pulses an error and counts errors.

Parameters:
- DATA_WIDTH, 8, character bits per frame. Legal range 5..9.
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- parity_type  in  3  000 none, 001 odd, 010 even, 011 mark (always 1), 100 space (always 0), 101..111 none. Sampled only on start.
- check_en  in  1  1 = Rx use (expect a parity bit), 0 = Tx use (generate only). Sampled on start.
- start  in  1  begin new frame; clears accumulator.
- bit_valid  in  1  strobe: bit_in is the next data bit.
- bit_in  in  1  data bit, any order (XOR is order-independent).
- chk_valid  in  1  strobe: chk_bit is the received parity bit.
- chk_bit  in  1  received parity bit.
- clr_err  in  1  synchronous clear of err_count.
- busy  out  1  high in ACCUM and WAIT_CHK.
- parity_valid  out  1  one-cycle pulse; parity_bit is final.
- parity_bit  out  1  registered parity for the frame; held until the next start.
- parity_err  out  1  one-cycle pulse on a mismatch.
- err_count  out  ERR_CNT_W  saturating count of parity errors.

Behaviour:
- Reset values: state IDLE, busy 0, parity_valid 0, parity_bit 1, parity_err 0, err_count 0, accumulator 0, bit counter 0.
- FSM states: IDLE, ACCUM, DONE, WAIT_CHK.
- IDLE: start -> ACCUM. Latch parity_type and check_en; acc=0; cnt=0. A bit_valid in the start cycle is ignored.
- ACCUM: each bit_valid does acc ^= bit_in and cnt += 1. The bit_valid with cnt == DATA_WIDTH-1 moves to DONE. cnt is $clog2(DATA_WIDTH+1) bits wide and never wraps.
- DONE lasts exactly one cycle:
  - parity_valid=1.
  - parity_bit is registered on entry: odd ~acc, even acc, mark 1, space 0, none 1.
  - Next state: WAIT_CHK if check_en=1 and the mode is not none; otherwise IDLE.
- Latency: parity_valid is asserted the cycle after the last bit_valid.
- WAIT_CHK: on chk_valid, parity_err pulses for one cycle the cycle after chk_valid when chk_bit != parity_bit, then -> IDLE. No timeout.
- Strobes outside their state are ignored: bit_valid outside ACCUM, chk_valid outside WAIT_CHK.
- start in ACCUM, DONE or WAIT_CHK aborts the frame:
  - Restart as from IDLE, using the new parity_type and check_en.
  - No parity_err; a bit_valid or chk_valid in that cycle is discarded.
  - start in DONE still emits that cycle's parity_valid.
- err_count increments by 1 on each parity_err and saturates at 2^ERR_CNT_W-1.
- clr_err in the same cycle as an increment: clear wins, result 0.
- Asserting reset mid-frame forces all reset values immediately (asynchronous); no pulses are emitted.

Optional Feature:
- Macro: UART_PARITY_ERRCNT_EN.
- Defined: err_count is implemented as above.
- Undefined: the counter is not implemented, err_count is tied to 0, and clr_err is ignored. parity_err pulses are unchanged.

Test Plan:
- DATA_WIDTH=8, even, check_en=0; start, then bits of 0xA5 LSB-first (4 ones) -> parity_valid one cycle after the 8th bit, parity_bit=0, busy=0 the next cycle, no parity_err.
- Odd, check_en=1; bits of 0x07, then chk_valid with chk_bit=0 -> parity_bit=0, no parity_err, err_count stays 0. Repeat with chk_bit=1 -> parity_err pulses once, err_count=1.
- Mark and space with 0x00, then none with 0xFF, check_en=1:
  - mark -> parity_bit=1.
  - space -> parity_bit=0.
  - none -> parity_bit=1, FSM back in IDLE the cycle after DONE, chk_valid ignored.
- Abort: even, 4 bits of 1, then start asserted together with bit_valid -> new frame of 0x01 (bits 1,0,0,0,0,0,0,0) gives parity_bit=1, proving the old bits and the discarded bit were cleared.
- ERR_CNT_W=2: force 5 mismatches -> err_count 1,2,3,3,3. clr_err asserted in the same cycle as a mismatch -> err_count=0.
- Reset asserted in WAIT_CHK -> busy=0, parity_bit=1, err_count=0 before the next clk edge, no parity_err. Rebuild without UART_PARITY_ERRCNT_EN -> err_count stays 0 throughout the mismatch test.
